// File: rtl/mmult_host.sv
// Host initiator for the 3x3 mmult engine: loads 18 bytes into A/B, runs mmult, streams 9 results.
// mm_enable rises 1 cycle after the last byte; in_ready=0 outside LOAD; out_data holds while out_ready=0.
module mmult_host #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         mm_enable,
    output logic [0:71]  mm_A_mat,
    output logic [0:71]  mm_B_mat,
    input  logic         mm_valid,
    input  logic [0:152] mm_C_mat,
    output logic         out_valid,
    output logic [16:0]  out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_SEND
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            armed_q;
    logic [4:0]      byte_cnt_q;
    logic [3:0]      elem_cnt_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [0:152]    c_shadow_q;

    logic            in_fire;
    logic            out_fire;
    logic            capture;
    logic            abort;
    logic            enable_d;
    logic [3:0]      slot;

    // armed_q keeps in_ready low until the first edge after reset release
    assign in_ready  = armed_q && (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_SEND);
    assign out_last  = out_valid && (elem_cnt_q == 4'd8);
    assign out_data  = out_valid ? c_shadow_q[17*elem_cnt_q +: 17] : 17'd0;
    assign busy      = (state_q != ST_LOAD);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign slot     = (byte_cnt_q < 5'd9) ? byte_cnt_q[3:0] : 4'(byte_cnt_q - 5'd9);

    always_comb begin
        state_d  = state_q;
        enable_d = mm_enable;
        capture  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_fire && (byte_cnt_q == 5'd17)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d  = ST_WAIT;
                enable_d = 1'b1;
            end
            ST_WAIT: begin
                if (mm_valid) begin
                    state_d  = ST_SEND;
                    enable_d = 1'b0;
                    capture  = 1'b1;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d  = ST_LOAD;
                    enable_d = 1'b0;
                    abort    = 1'b1;
                end
            end
            ST_SEND: begin
                if (out_fire && out_last) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d  = ST_LOAD;
                enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            armed_q     <= 1'b0;
            mm_enable   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= 1'b1;
            mm_enable   <= enable_d;
            timeout_err <= abort;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= 5'd0;
            elem_cnt_q <= 4'd0;
            tmo_cnt_q  <= '0;
            mm_A_mat   <= '0;
            mm_B_mat   <= '0;
            c_shadow_q <= '0;
        end else begin
            if (in_fire) begin
                if (byte_cnt_q < 5'd9) begin
                    mm_A_mat[8*slot +: 8] <= in_data;
                end else begin
                    mm_B_mat[8*slot +: 8] <= in_data;
                end
                byte_cnt_q <= (byte_cnt_q == 5'd17) ? 5'd0 : byte_cnt_q + 5'd1;
            end

            if (state_q == ST_START) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (capture) begin
                c_shadow_q <= mm_C_mat;
            end

            // an aborted job must not leak stale operands into the next one
            if (abort) begin
                mm_A_mat   <= '0;
                mm_B_mat   <= '0;
                byte_cnt_q <= 5'd0;
            end

            if (out_fire) begin
                elem_cnt_q <= out_last ? 4'd0 : elem_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmult_host.sv
// Directed bench for mmult_host with a behavioural mmult stub (valid after 6 enabled edges).
module tb_mmult_host;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         mm_enable;
    logic [0:71]  mm_A_mat;
    logic [0:71]  mm_B_mat;
    logic         mm_valid;
    logic [0:152] mm_C_mat;
    logic         out_valid;
    logic [16:0]  out_data;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         timeout_err;

    always #5 clk = ~clk;

    mmult_host #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mm_enable(mm_enable), .mm_A_mat(mm_A_mat), .mm_B_mat(mm_B_mat),
        .mm_valid(mm_valid), .mm_C_mat(mm_C_mat),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [8:0][7:0]  a;
        logic [8:0][7:0]  b;
        logic [8:0][16:0] c;
    } vec_t;

    vec_t tv[4];
    localparam int C2[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

    int n_vec = 0;
    int n_bad = 0;

    // mmult stub
    int stub_cnt;
    bit stub_dead = 1'b0;

    function automatic logic [0:152] stub_mult(input logic [0:71] a, input logic [0:71] b);
        logic [0:152] r;
        logic [16:0]  s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 17'd0;
                for (int m = 0; m < 3; m++) begin
                    s = s + 17'(a[8*(3*i+m) +: 8]) * 17'(b[8*(3*m+j) +: 8]);
                end
                r[17*(3*i+j) +: 17] = s;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stub_cnt <= 0;
            mm_valid <= 1'b0;
            mm_C_mat <= '0;
        end else if (!mm_enable) begin
            stub_cnt <= 0;
            mm_valid <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 5 && !stub_dead) begin
                mm_valid <= 1'b1;
                mm_C_mat <= stub_mult(mm_A_mat, mm_B_mat);
            end
        end
    end

    // event timestamps
    time t_en_rise = 0;
    time t_ov_rise = 0;
    time t_to      = 0;
    time t_xfer    = 0;
    int  en_rises  = 0;
    int  to_pulses = 0;

    always @(posedge mm_enable) begin
        t_en_rise = $time;
        en_rises++;
    end
    always @(posedge out_valid) t_ov_rise = $time;
    always @(posedge timeout_err) begin
        t_to = $time;
        to_pulses++;
    end

    task automatic chk(input string nm, input logic [152:0] act, input logic [152:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_job(input int v, input bit hold);
        int g;
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (n < 9) ? tv[v].a[n] : tv[v].b[n-9];
            g = 0;
            while (!in_ready && g < 300) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready) chk($sformatf("v%0d_in_ready_wait", v), in_ready, 1);
            @(posedge clk);
        end
        t_xfer = $time;
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // returns at the negedge where element abort_at is presented, if abort_at is in 0..8
    task automatic recv_job(input int v, input int stall_at, input int abort_at);
        int g;
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            g = 0;
            while (!out_valid && g < 300) begin
                @(negedge clk);
                g++;
            end
            if (!out_valid) chk($sformatf("v%0d_out_valid_wait", v), out_valid, 1);
            if (e == abort_at) return;
            chk($sformatf("v%0d_data%0d", v, e), out_data, tv[v].c[e]);
            chk($sformatf("v%0d_last%0d", v, e), out_last, (e == 8));
            if (e == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk($sformatf("v%0d_hold_data%0d", v, s), out_data, tv[v].c[e]);
                    chk($sformatf("v%0d_hold_valid%0d", v, s), out_valid, 1);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 9; k++) begin
            tv[0].a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
            tv[0].b[k] = 8'(k + 1);
            tv[0].c[k] = 17'(k + 1);
            tv[1].a[k] = 8'd255;
            tv[1].b[k] = 8'd255;
            tv[1].c[k] = 17'd64003;
            tv[2].a[k] = 8'(k + 1);
            tv[2].b[k] = 8'(k + 1);
            tv[2].c[k] = 17'(C2[k]);
            tv[3].a[k] = (k % 4 == 0) ? 8'd2 : 8'd0;
            tv[3].b[k] = 8'(9 - k);
            tv[3].c[k] = 17'(2 * (9 - k));
        end

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {in_ready, mm_enable, out_valid, out_last, busy, timeout_err, out_data}, 0);
        chk("reset_a_b", {mm_A_mat, mm_B_mat}, 0);
        reset_n = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", in_ready, 1);
        chk("busy_idle", busy, 0);

        // table: each vector as a standalone job
        for (int v = 0; v < 4; v++) begin
            send_job(v, 1'b0);
            recv_job(v, -1, -1);
            if (v == 0) begin
                chk("lat_enable", t_en_rise - t_xfer, 10);
                chk("lat_out_valid", t_ov_rise - t_xfer, 80);
                chk("packed_a", mm_A_mat, {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1});
            end
            @(negedge clk);
            chk($sformatf("v%0d_idle", v), {out_valid, busy, mm_enable, in_ready}, 4'b0001);
        end

        // output backpressure at element 4
        send_job(0, 1'b0);
        recv_job(0, 4, -1);

        // mmult never answers
        stub_dead = 1'b1;
        send_job(0, 1'b0);
        begin
            int g;
            g = 0;
            while (!timeout_err && g < 100) begin
                @(negedge clk);
                g++;
            end
        end
        chk("timeout_pulse", timeout_err, 1);
        chk("timeout_delay", t_to - t_en_rise, 160);
        chk("timeout_state", {mm_enable, in_ready, busy, out_valid}, 4'b0100);
        @(negedge clk);
        chk("timeout_one_cycle", timeout_err, 0);
        chk("timeout_count", to_pulses, 1);
        stub_dead = 1'b0;

        // back-to-back jobs with in_valid held high
        begin
            int en0;
            en0 = en_rises;
            fork
                begin
                    send_job(2, 1'b1);
                    send_job(3, 1'b0);
                end
                begin
                    recv_job(2, -1, -1);
                    recv_job(3, -1, -1);
                end
            join
            chk("b2b_enable_rises", en_rises - en0, 2);
        end

        // async reset in the middle of SEND
        send_job(2, 1'b0);
        recv_job(2, -1, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {in_ready, mm_enable, out_valid, out_last, busy, timeout_err, out_data}, 0);
        chk("async_reset_a_b", {mm_A_mat, mm_B_mat}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_job(3, 1'b0);
        recv_job(3, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
